// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MEM-stage to data-bus bridge.
// The watchdog width helper keeps a disabled watchdog (timeout 0) at a legal 1-bit width.
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } bus_state_t;

    localparam logic [STRB_W-1:0] WSTRB_NONE = 4'b0000;

    // Latched copy of the pipeline request driven onto the bus.
    typedef struct packed {
        logic              wr;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    function automatic int unsigned wdog_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Transaction watchdog: cleared on load, counts enabled cycles, flags expiry on
// the cycle the count would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 never expires.
module mem_bus_watchdog
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = wdog_width(TIMEOUT_CYCLES);
    localparam int unsigned LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is seen during the TIMEOUT_CYCLES-th busy cycle so the abort lands on that edge.
    assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == CNT_W'(LAST));

endmodule

// File: rtl/mem_bus_bridge.sv
// Converts single-cycle MEM-stage requests into a split address/data bus
// handshake, stalling the pipeline until the bus completes or the watchdog aborts.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [STRB_W-1:0] mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              hold,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    bus_state_t        state, state_nxt;
    bus_cmd_t          cmd, cmd_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic              err_nxt;
    logic              req_nxt;
    logic              abandoned, abandoned_nxt;
    logic              wd_load, wd_enable, wd_expire;

    assign wd_load   = (state == IDLE) && mem_en;
    assign wd_enable = (state == ADDR) || (state == DATA);

    mem_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (wd_load),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd       <= '0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            abandoned <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd       <= cmd_nxt;
            mem_rdata <= rdata_nxt;
            bus_err   <= err_nxt;
            bus_req   <= req_nxt;
            abandoned <= abandoned_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd;
        rdata_nxt     = mem_rdata;
        err_nxt       = bus_err;
        req_nxt       = bus_req;
        abandoned_nxt = abandoned;

        case (state)
            IDLE: begin
                if (mem_en) begin
                    cmd_nxt.wr    = (mem_wen != WSTRB_NONE);
                    cmd_nxt.wstrb = mem_wen;
                    cmd_nxt.addr  = mem_addr;
                    cmd_nxt.wdata = mem_wdata;
                    req_nxt       = 1'b1;
                    abandoned_nxt = 1'b0;
                    state_nxt     = ADDR;
                end
            end

            ADDR: begin
                if (!mem_en) begin
                    abandoned_nxt = 1'b1;
                end
                // A completing response beats a watchdog expiry on the same cycle.
                if (bus_addr_ok && bus_data_ok) begin
                    if (!cmd.wr) begin
                        rdata_nxt = bus_rdata;
                    end
                    req_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (wd_expire) begin
                    if (!cmd.wr) begin
                        rdata_nxt = ERR_RDATA;
                    end
                    err_nxt   = 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (bus_addr_ok) begin
                    req_nxt   = 1'b0;
                    state_nxt = DATA;
                end
            end

            DATA: begin
                if (!mem_en) begin
                    abandoned_nxt = 1'b1;
                end
                if (bus_data_ok) begin
                    if (!cmd.wr) begin
                        rdata_nxt = bus_rdata;
                    end
                    state_nxt = DONE;
                end else if (wd_expire) begin
                    if (!cmd.wr) begin
                        rdata_nxt = ERR_RDATA;
                    end
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                // A flushed request has no instruction waiting to retire, so hold is moot.
                if (!hold || abandoned) begin
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign stall     = rst && mem_en && (state != DONE);
    assign bus_wr    = cmd.wr;
    assign bus_wstrb = cmd.wstrb;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits directly downstream of the MEM-stage memory unit and consumes its mem_en / mem_wen / mem_addr / mem_wdata request.
- Converts each single-cycle pipeline request into a split address/data handshake on the data-side SRAM-like bus.
- Stalls the pipeline until the bus transaction completes, then returns registered read data.
- A watchdog terminates hung transactions with an error flag.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in ADDR+DATA before forced abort; 0 disables the watchdog.
- ERR_RDATA, 32'h0000_0000: value returned on mem_rdata for an aborted read.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- mem_en  input  1  request valid from MEM stage
- mem_wen  input  4  byte write strobes; 0 = read
- mem_addr  input  32  physical address
- mem_wdata  input  32  write data (already lane-replicated)
- hold  input  1  pipeline frozen by another stage; MEM request must not retire
- mem_rdata  output  32  read data, valid in DONE
- stall  output  1  pipeline stall request
- bus_err  output  1  watchdog abort flag, valid in DONE
- bus_req  output  1  address-phase request
- bus_wr  output  1  1 = write
- bus_wstrb  output  4  byte strobes
- bus_addr  output  32  address
- bus_wdata  output  32  write data
- bus_addr_ok  input  1  address accepted this cycle (while bus_req=1)
- bus_data_ok  input  1  read data / write response this cycle
- bus_rdata  input  32  read data, valid with bus_data_ok

Behaviour:
- Reset: rst=0 asynchronously forces state IDLE, watchdog counter 0, and all registered outputs 0 (mem_rdata, bus_err, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata). stall is combinational and is 0 under reset.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - mem_en=1: latch wen/addr/wdata into bus_* registers; bus_req=1 from the next cycle; go to ADDR.
  - Otherwise stay in IDLE.
- ADDR: bus_req=1.
  - bus_addr_ok & bus_data_ok in the same cycle: capture rdata (reads only), drop req, go to DONE.
  - bus_addr_ok only: drop req, go to DATA.
- DATA: bus_req=0. bus_data_ok: capture bus_rdata when bus_wr=0, go to DONE.
  - bus_data_ok is honoured only in DATA or ADDR; it is ignored in IDLE and DONE.
- DONE: mem_rdata holds the result and stall=0.
  - hold=0: go to IDLE next cycle; the pipeline retires the instruction on this edge.
  - hold=1: stay in DONE and do not reissue the request.
- stall = mem_en & (state != DONE). This is combinational and asserts in the same cycle mem_en rises. stall=0 whenever mem_en=0.
- The pipeline keeps mem_* stable while stall=1. The bridge relies only on its latched copy.
- Back-to-back requests: a new mem_en in the IDLE cycle after DONE is accepted immediately, so minimum occupancy is 3 cycles: IDLE, ADDR (addr_ok+data_ok), DONE.
- Latency: request with addr_ok and data_ok both in the first ADDR cycle → stall high for 2 cycles, result in cycle 3.
- Watchdog:
  - Counter clears on entry to ADDR and increments each cycle in ADDR/DATA.
  - When it reaches TIMEOUT_CYCLES: drop bus_req, mem_rdata=ERR_RDATA (reads), bus_err=1, go to DONE.
  - bus_err clears on leaving DONE.
  - A bus_data_ok arriving on the expiry cycle wins: normal completion, bus_err=0.
- Abandoned request: if mem_en drops while in ADDR/DATA (flush), the bus transaction still completes, DONE is passed through silently, and stall stays 0.
- Reset mid-transaction: the bus side is abandoned and the slave is required to tolerate a dropped req.

Decomposition:
- Shared package mem_bus_pkg holds:
  - typedef enum logic [1:0] bus_state_t {IDLE, ADDR, DATA, DONE}
  - constant WSTRB_NONE = 4'b0000
- The watchdog is a natural single sub-module, mem_bus_watchdog: load, enable, expire, parameterised width $clog2(TIMEOUT_CYCLES+1).
- Everything else stays in one always_ff/always_comb pair.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0; release → stall follows mem_en.
- Read, addr_ok+data_ok same cycle: mem_en=1, wen=0, addr=32'h0000_1000, bus_rdata=32'hCAFE_F00D → stall high 2 cycles, mem_rdata=32'hCAFE_F00D in DONE, bus_err=0.
- Write with 3-cycle addr delay and 2-cycle data delay: wen=4'b0100, wdata=32'hABAB_ABAB → bus_req held exactly until addr_ok, bus_wstrb=4'b0100, stall high 6 cycles.
- Back-to-back read then write: second request issues bus_req exactly 1 cycle after the first DONE; no duplicate bus_req for the first request.
- hold=1 in DONE for 4 cycles → state stays DONE, mem_rdata stable, stall=0, no new bus_req; hold drops → IDLE.
- Timeout: TIMEOUT_CYCLES=8, slave never asserts addr_ok → bus_req drops after 8 cycles, bus_err=1 and mem_rdata=ERR_RDATA for one DONE cycle; repeat with data_ok on cycle 8 → normal completion.
